// File: rtl/of_common_pkg.sv
// Shared types and constants for the optical-flow line-buffer sequencing logic.
package of_common_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } lb_ctrl_state_e;

    localparam int LB_WIN  = 5;
    localparam int LB_HALF = 2;

    localparam int DEF_WIDTH  = 320;
    localparam int DEF_HEIGHT = 240;
    localparam int DEF_X_W    = $clog2(DEF_WIDTH);
    localparam int DEF_Y_W    = $clog2(DEF_HEIGHT);

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_pos_counter.sv
// Raster col/row position counter; flags the last pixel of the frame.
module pixel_pos_counter
    import of_common_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int X_W    = coord_w(WIDTH),
    parameter int Y_W    = coord_w(HEIGHT)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_clear,
    input  logic           i_en,
    output logic [X_W-1:0] o_col,
    output logic [Y_W-1:0] o_row,
    output logic           o_frame_end
);

    logic [X_W-1:0] r_col;
    logic [Y_W-1:0] r_row;
    logic           w_col_last;
    logic           w_row_last;

    assign w_col_last = (r_col == X_W'(WIDTH - 1));
    assign w_row_last = (r_row == Y_W'(HEIGHT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col       = r_col;
    assign o_row       = r_row;
    assign o_frame_end = w_col_last && w_row_last;

endmodule

// File: rtl/line_buffer_5x5_ctrl.sv
// Frame sequencer for the 5x5 line buffer: gates upstream pixels, tracks window centres, flags desync.
//   state  | meaning
//   IDLE   | waiting for frame_start
//   STREAM | accepting pixels while the current window is consumed
//   DRAIN  | all pixels pushed, waiting for the final window to be taken
//   DONE   | one-cycle frame_done, then back to IDLE
module line_buffer_5x5_ctrl
    import of_common_pkg::*;
#(
    parameter  int WIDTH      = DEF_WIDTH,
    parameter  int HEIGHT     = DEF_HEIGHT,
    parameter  int DATA_WIDTH = 12,
    localparam int X_W        = coord_w(WIDTH),
    localparam int Y_W        = coord_w(HEIGHT)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         frame_start,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic signed [DATA_WIDTH-1:0] lb_data,
    output logic                         lb_valid,
    input  logic                         lb_window_valid,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [X_W-1:0]               m_x,
    output logic [Y_W-1:0]               m_y,
    output logic                         m_last,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         err_sync
);

    lb_ctrl_state_e r_state;
    logic           r_m_valid;
    logic [X_W-1:0] r_m_x;
    logic [Y_W-1:0] r_m_y;
    logic           r_m_last;
    logic           r_push_d;
    logic           r_err_sync;

    logic           w_clear;
    logic           w_ready;
    logic           w_push;
    logic           w_win;
    logic [X_W-1:0] w_col;
    logic [Y_W-1:0] w_row;
    logic           w_frame_end;

    assign w_clear = (r_state == ST_IDLE) && frame_start;
    assign w_ready = (r_state == ST_STREAM) && (!r_m_valid || m_ready);
    assign w_push  = s_valid && w_ready;
    assign w_win   = (w_col >= X_W'(LB_WIN - 1)) && (w_row >= Y_W'(LB_WIN - 1));

    pixel_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_pos (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_clear),
        .i_en        (w_push),
        .o_col       (w_col),
        .o_row       (w_row),
        .o_frame_end (w_frame_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:   if (frame_start) r_state <= ST_STREAM;
                ST_STREAM: if (w_push && w_frame_end) r_state <= ST_DRAIN;
                ST_DRAIN:  if (!r_m_valid || m_ready) r_state <= ST_DONE;
                ST_DONE:   r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // A freshly registered window takes priority over retiring the one just consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_x     <= '0;
            r_m_y     <= '0;
            r_m_last  <= 1'b0;
        end else if (w_push && w_win) begin
            r_m_valid <= 1'b1;
            r_m_x     <= w_col - X_W'(LB_HALF);
            r_m_y     <= w_row - Y_W'(LB_HALF);
            r_m_last  <= w_frame_end;
        end else if (r_m_valid && m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_push_d   <= 1'b0;
            r_err_sync <= 1'b0;
        end else begin
            r_push_d <= w_push;
            if ((r_push_d && (lb_window_valid != r_m_valid)) ||
                (frame_start && (r_state != ST_IDLE)))
                r_err_sync <= 1'b1;
        end
    end

    assign s_ready    = w_ready;
    assign lb_valid   = w_push;
    assign lb_data    = s_data;
    assign m_valid    = r_m_valid;
    assign m_x        = r_m_x;
    assign m_y        = r_m_y;
    assign m_last     = r_m_last;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = (r_state == ST_DONE);
    assign err_sync   = r_err_sync;

endmodule

// File: tb/tb_line_buffer_5x5_ctrl.sv
// Randomized bench for line_buffer_5x5_ctrl against a raster-order window model (8x6 frame).
module tb_line_buffer_5x5_ctrl;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int DW   = 12;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 4) * (H - 4);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 frame_start = 1'b0;
    logic signed [DW-1:0] s_data = '0;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [DW-1:0] lb_data;
    logic                 lb_valid;
    logic                 lb_window_valid;
    logic                 m_valid;
    logic                 m_ready = 1'b0;
    logic [2:0]           m_x;
    logic [2:0]           m_y;
    logic                 m_last;
    logic                 busy;
    logic                 frame_done;
    logic                 err_sync;
    logic                 inject = 1'b0;
    logic                 lb_wv;

    line_buffer_5x5_ctrl #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .lb_data(lb_data), .lb_valid(lb_valid), .lb_window_valid(lb_window_valid),
        .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .m_last(m_last),
        .busy(busy), .frame_done(frame_done), .err_sync(err_sync)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model state, owned by the monitor.
    int  n = 0;
    bit  in_frame = 0;
    bit  err_m = 0;
    int  q_x[$], q_y[$], q_l[$];
    int  cons_x[$], cons_y[$], cons_l[$];
    int  cons_cnt = 0;
    int  fd_count = 0;
    int  cyc_cnt = 0;
    int  last_cons_cyc = 0;
    int  fd_cyc = 0;
    bit  push_prev = 0, prev_win = 0, prev_hold = 0, prev_fd = 0;
    int  prev_c = 0, prev_r = 0, prev_mx = 0, prev_my = 0;
    bit  lb_wv_next = 0;

    // Stand-in for the line buffer's window_valid: one cycle after a push that completes a 5x5 window.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lb_wv <= 1'b0;
        else        lb_wv <= lb_wv_next;
    end
    assign lb_window_valid = lb_wv ^ inject;

    always @(negedge clk) begin
        int  c, r;
        bit  win, exp_sready, start_ok;
        cyc_cnt++;
        if (!rst_n) begin
            chk("rst s_ready", s_ready, 0);
            chk("rst lb_valid", lb_valid, 0);
            chk("rst m_valid", m_valid, 0);
            chk("rst m_last", m_last, 0);
            chk("rst m_x", m_x, 0);
            chk("rst m_y", m_y, 0);
            chk("rst busy", busy, 0);
            chk("rst frame_done", frame_done, 0);
            chk("rst err_sync", err_sync, 0);
            n = 0; in_frame = 0; err_m = 0; cons_cnt = 0;
            q_x.delete(); q_y.delete(); q_l.delete();
            push_prev = 0; prev_hold = 0; prev_fd = 0; prev_win = 0;
            lb_wv_next = 0;
        end else begin
            chk("busy", busy, in_frame);
            exp_sready = in_frame && (n < NPIX) && (!m_valid || m_ready);
            chk("s_ready", s_ready, exp_sready);
            chk("lb_valid", lb_valid, s_valid && exp_sready);
            if (lb_valid) chk("lb_data", lb_data, s_data);
            if (push_prev) begin
                chk("window latency", m_valid, prev_win);
                if (prev_win) begin
                    chk("m_x", m_x, prev_c - 2);
                    chk("m_y", m_y, prev_r - 2);
                    chk("m_last", m_last, (prev_c == W-1 && prev_r == H-1));
                end
            end else if (prev_hold) begin
                chk("held m_valid", m_valid, 1);
                chk("held m_x", m_x, prev_mx);
                chk("held m_y", m_y, prev_my);
            end
            if (prev_fd) chk("frame_done pulse width", frame_done, 0);
            chk("err_sync", err_sync, err_m);
            if (m_valid && m_ready) begin
                if (q_x.size() == 0) chk("spurious window", 1, 0);
                else begin
                    int ex, ey, el;
                    ex = q_x.pop_front(); ey = q_y.pop_front(); el = q_l.pop_front();
                    chk("consumed x", m_x, ex);
                    chk("consumed y", m_y, ey);
                    chk("consumed last", m_last, el);
                end
                cons_cnt++;
                cons_x.push_back(m_x); cons_y.push_back(m_y); cons_l.push_back(m_last);
                last_cons_cyc = cyc_cnt;
            end
            if (frame_done) begin
                chk("windows per frame", cons_cnt, NWIN);
                chk("pixels per frame", n, NPIX);
                chk("pending windows at done", q_x.size(), 0);
                fd_count++;
                fd_cyc = cyc_cnt;
            end
            if (push_prev && (lb_window_valid != prev_win)) err_m = 1;
            if (frame_start && in_frame) err_m = 1;
            c = n % W; r = n / W;
            win = lb_valid && (c >= 4) && (r >= 4);
            if (lb_valid) begin
                if (win) begin
                    q_x.push_back(c - 2); q_y.push_back(r - 2);
                    q_l.push_back(c == W-1 && r == H-1);
                end
                n++;
            end
            push_prev = lb_valid; prev_c = c; prev_r = r; prev_win = win;
            lb_wv_next = win;
            prev_hold = m_valid && !m_ready; prev_mx = m_x; prev_my = m_y;
            prev_fd = frame_done;
            start_ok = frame_start && !in_frame;
            if (frame_done) in_frame = 0;
            if (start_ok) begin
                in_frame = 1; n = 0; cons_cnt = 0;
                cons_x.delete(); cons_y.delete(); cons_l.delete();
            end
        end
    end

    task automatic run_frame(input int pv, input int pr, input bit hold,
                             input int inj_at, input int mid_at, input int rst_at);
        int start_fd;
        int hold_cnt;
        bit done, inj_done, mid_done;
        start_fd = fd_count; hold_cnt = 0; done = 0; inj_done = 0; mid_done = 0;
        @(posedge clk); #1;
        frame_start = 1; s_valid = 0; m_ready = 1;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(posedge clk); #1;
            frame_start = 0; inject = 0;
            s_valid = ($urandom_range(99) < pv);
            s_data  = DW'($urandom);
            m_ready = ($urandom_range(99) < pr);
            if (hold && m_valid && hold_cnt < 10) begin
                m_ready = 0; hold_cnt++;
                #1;
                chk("hold s_ready", s_ready, 0);
                chk("hold lb_valid", lb_valid, 0);
                chk("hold m_valid", m_valid, 1);
                chk("hold m_x", m_x, 2);
                chk("hold m_y", m_y, 2);
            end
            if (inj_at >= 0 && !inj_done && n == inj_at) begin inject = 1; inj_done = 1; end
            if (mid_at >= 0 && !mid_done && n == mid_at) begin frame_start = 1; mid_done = 1; end
            if (rst_at >= 0 && n == rst_at) begin
                rst_n = 0; s_valid = 0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1;
                return;
            end
            if (fd_count != start_fd) done = 1;
        end
        if (!done) chk("frame timeout", 0, 1);
        s_valid = 0; inject = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        run_frame(100, 100, 0, -1, -1, -1);
        chk("f1 window count", cons_x.size(), 8);
        if (cons_x.size() == 8) begin
            chk("f1 first x", cons_x[0], 2);
            chk("f1 first y", cons_y[0], 2);
            chk("f1 fifth x", cons_x[4], 2);
            chk("f1 fifth y", cons_y[4], 3);
            chk("f1 last x", cons_x[7], 5);
            chk("f1 last y", cons_y[7], 3);
            chk("f1 last flag", cons_l[7], 1);
            chk("f1 non-last flag", cons_l[6], 0);
        end
        chk("f1 done after last consume", fd_cyc - last_cons_cyc, 1);
        chk("f1 err_sync", err_sync, 0);

        run_frame(100, 100, 1, -1, -1, -1);
        chk("hold frame windows", cons_x.size(), 8);

        for (int f = 0; f < 3; f++) run_frame(50, 50, 0, -1, -1, -1);
        chk("random frames done", fd_count, 5);
        chk("random err_sync", err_sync, 0);

        run_frame(100, 100, 0, -1, 10, -1);
        chk("mid start windows", cons_x.size(), 8);
        chk("mid start err_sync", err_sync, 1);

        run_frame(100, 100, 0, -1, -1, 20);
        @(posedge clk); #1;
        chk("post-reset err_sync", err_sync, 0);
        chk("post-reset busy", busy, 0);
        chk("reset frame no done", fd_count, 6);
        run_frame(100, 100, 0, -1, -1, -1);
        chk("post-reset windows", cons_x.size(), 8);

        run_frame(100, 100, 0, 30, -1, -1);
        chk("desync err_sync", err_sync, 1);
        repeat (4) @(posedge clk);
        #1 chk("desync err_sync sticky", err_sync, 1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/line_buffer_5x5_ctrl.md
Name: line_buffer_5x5_ctrl

Overview:
- Sequences one frame at a time through the 5x5 line buffer, which has no backpressure and no frame framing of its own.
- Gates upstream pixels with a ready/valid handshake so each window is consumed downstream before the next push.
- Tracks the window-centre coordinates and frame boundaries, and flags desync against the line buffer's own window_valid.
- Sits between the pixel source (gradient/derivative stage) and the 5x5 accumulation stage of the optical-flow pipeline.

Parameters:
- WIDTH, 320, pixels per line; must match the line buffer.
- HEIGHT, 240, lines per frame; must match the line buffer.
- DATA_WIDTH, 12, signed pixel width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low. Also drives the line buffer's rst_n.
- frame_start  in  1  single-cycle pulse; arms capture of one frame.
- s_data  in  DATA_WIDTH  upstream pixel, signed.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  controller accepts pixel this cycle.
- lb_data  out  DATA_WIDTH  pixel to line buffer data_in.
- lb_valid  out  1  to line buffer data_valid.
- lb_window_valid  in  1  from line buffer window_valid.
- m_valid  out  1  window (on line buffer window outputs) valid for consumer.
- m_ready  in  1  consumer accepts window.
- m_x  out  $clog2(WIDTH)  window centre column.
- m_y  out  $clog2(HEIGHT)  window centre row.
- m_last  out  1  final window of frame.
- busy  out  1  state != IDLE.
- frame_done  out  1  single-cycle pulse at frame completion.
- err_sync  out  1  sticky; cleared only by rst_n.

Behaviour:
- States: IDLE, STREAM, DRAIN, DONE (enum in package).
- Reset values: state=IDLE; counters 0; s_ready, lb_valid, m_valid, m_last, frame_done, err_sync all 0; m_x/m_y 0.
- IDLE -> STREAM on frame_start; col=row=0.
- s_ready = (state==STREAM) && (!m_valid || m_ready). Combinational, no dependence on s_valid.
- push = s_valid && s_ready. lb_valid = push and lb_data = s_data, both combinational pass-through (zero latency).
- On push at (col,row):
  - Advance col; at WIDTH-1 wrap col to 0 and increment row.
  - If col>=4 && row>=4, next cycle register m_valid=1, m_x=col-2, m_y=row-2, m_last=(col==WIDTH-1 && row==HEIGHT-1).
  - Push of pixel (WIDTH-1, HEIGHT-1) moves state to DRAIN.
- m_valid handling:
  - Cleared on m_valid && m_ready unless a new window is registered the same cycle; the new window wins.
  - While m_valid && !m_ready: no push, so the line buffer window stays stable.
- Window latency: 1 cycle after push, aligned with lb_window_valid.
- DRAIN: wait until m_valid==0, or m_valid && m_ready, then go to DONE.
- DONE: frame_done=1 for one cycle, then IDLE. busy=0 in IDLE only.
- err_sync sets when:
  - lb_window_valid != m_valid on the cycle after any push;
  - frame_start arrives while state != IDLE. The pulse is ignored and the frame in progress continues.
- Frame geometry: windows per frame = (WIDTH-4)*(HEIGHT-4). Windows with col<4 or row<4 are never emitted (no padding).
- Reset mid-frame: everything returns to reset values; the line buffer resets on the same rst_n. A partial frame is discarded with no frame_done.
- s_valid outside STREAM is ignored; the pixel is not consumed.

Decomposition:
- Package of_common_pkg:
  - lb_ctrl_state_e enum;
  - LB_WIN=5 and LB_HALF=2 constants;
  - coordinate width localparams.
- Sub-module pixel_pos_counter: col/row counter with enable, wrap and frame_end flag. Instantiated once.

Test Plan (WIDTH=8, HEIGHT=6):
- Reset, frame_start, 48 pixels with s_valid=1 and m_ready=1 -> exactly 8 m_valid beats, centres (2..5, 2..3) in raster order; m_last on (5,3); frame_done 1 cycle after last consumption; err_sync=0.
- Hold m_ready=0 for 10 cycles at the first window -> s_ready=0, lb_valid=0, m_valid, m_x=2, m_y=2 and line buffer window held stable; releasing resumes with no loss (8 windows total).
- Random s_valid/m_ready (50%) for 3 back-to-back frames -> 24 windows, 3 frame_done pulses, coordinates correct, no err_sync.
- frame_start pulsed mid-STREAM -> err_sync=1 sticky; current frame still completes with 8 windows.
- rst_n asserted after 20 pixels, then a new frame -> all outputs 0 during reset; the following frame yields 8 correct windows.
- Force lb_window_valid mismatched once -> err_sync=1 on that cycle and held.
